// File: rtl/bl_zone_scan_ctrl_pkg.sv
// bl_pkg: shared FSM state encoding, zone geometry defaults and counter width helper
//   stateT      : sequencer states (also driven on oState of bl_zone_scan_ctrl)
//   *_DEF       : default zone geometry and PWM duty modulus
//   cntWidth(n) : bits needed for a 0..n-1 counter (at least 1)
package bl_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_DE = 3'd1,
    ACTIVE  = 3'd2,
    CALC    = 3'd3,
    LOAD    = 3'd4
  } stateT;
  localparam int ZONE_W_DEF      = 240;
  localparam int ZONE_H_DEF      = 180;
  localparam int ZONE_COLS_DEF   = 8;
  localparam int ZONE_ROWS_DEF   = 6;
  localparam int DUTY_PERIOD_DEF = 80;
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bl_zone_scan_ctrl_counter.sv
// bl_mod_counter: mod-N counter with synchronous clear, increment enable and carry
//   iODCK    : clock, rising edge
//   iSYS_rst : async active-low reset
//   iClr     : synchronous clear (priority over iInc)
//   iInc     : advance by one, wrapping N-1 -> 0
//   oCount   : current count 0..N-1
//   oLast    : oCount == N-1
//   oCarry   : iInc while oLast (the count wraps on this edge)
module bl_mod_counter
  import bl_pkg::*;
#(
  parameter int N = 8,
  parameter int W = cntWidth(N)
) (
  input  logic         iODCK,
  input  logic         iSYS_rst,
  input  logic         iClr,
  input  logic         iInc,
  output logic [W-1:0] oCount,
  output logic         oLast,
  output logic         oCarry
);
  assign oLast  = oCount == W'(N - 1);
  assign oCarry = iInc & oLast;
  always_ff @(posedge iODCK or negedge iSYS_rst)
    if (!iSYS_rst) oCount <= '0;
    else if (iClr) oCount <= '0;
    else if (iInc) oCount <= oLast ? '0 : oCount + 1'b1;
endmodule

// File: rtl/bl_zone_scan_ctrl.sv
// bl_zone_scan_ctrl: backlight zone scan sequencer, calculator handshake and PWM duty phase
//   iODCK / iSYS_rst      : pixel clock, async active-low reset
//   iEn                   : block enable; low forces IDLE and clears all counters
//   iDE                   : data enable from the timing controller
//   iCalc_ack             : calculator done (level), only looked at in CALC
//   oH_Count / oV_Count   : pixel and line index of the last sampled DE
//   oZone_Col / oZone_Row : zone position
//   oZone_Valid           : registered iDE while a frame is being scanned
//   oZone_End / oLine_End / oFrame_End : single-cycle position pulses
//   oCalc_req / oPWM_load : calculator request (held) and duty load strobe
//   oH_Block_Duty_Count   : free-running 0..DUTY_PERIOD-1 duty phase
//   oErr_Overrun          : sticky, frame started while the calculator was busy
//   oState                : sequencer state
// Active area is ZONE_W*ZONE_COLS by ZONE_H*ZONE_ROWS.
module bl_zone_scan_ctrl
  import bl_pkg::*;
#(
  parameter int ZONE_W      = ZONE_W_DEF,
  parameter int ZONE_H      = ZONE_H_DEF,
  parameter int ZONE_COLS   = ZONE_COLS_DEF,
  parameter int ZONE_ROWS   = ZONE_ROWS_DEF,
  parameter int DUTY_PERIOD = DUTY_PERIOD_DEF
) (
  input  logic        iODCK,
  input  logic        iSYS_rst,
  input  logic        iEn,
  input  logic        iDE,
  input  logic        iCalc_ack,
  output logic [11:0] oH_Count,
  output logic [11:0] oV_Count,
  output logic [3:0]  oZone_Col,
  output logic [3:0]  oZone_Row,
  output logic        oZone_Valid,
  output logic        oZone_End,
  output logic        oLine_End,
  output logic        oFrame_End,
  output logic        oCalc_req,
  output logic        oPWM_load,
  output logic [6:0]  oH_Block_Duty_Count,
  output logic        oErr_Overrun,
  output stateT       oState
);
  localparam int HZW = cntWidth(ZONE_W);
  localparam int CW  = cntWidth(ZONE_COLS);
  localparam int VZW = cntWidth(ZONE_H);
  localparam int RW  = cntWidth(ZONE_ROWS);
  localparam int DW  = cntWidth(DUTY_PERIOD);
  stateT state, nextState;
  logic deQ, frameRun, satQ;
  logic frameStart, runNow, hFull, hStart, hStep, lineEv, frameEv, posClr;
  logic [HZW-1:0] hz;
  logic [CW-1:0]  col;
  logic [VZW-1:0] vz;
  logic [RW-1:0]  row;
  logic [DW-1:0]  duty;
  logic hzLast, hzCarry, colLast, colCarry, vzLast, vzCarry, rowLast, rowCarry;
  logic dutyLast, dutyCarry, unusedSigs;
  // A frame may also begin while the calculator is still busy (overrun) or during LOAD.
  assign frameStart = iEn & iDE & ~deQ & (state == WAIT_DE || state == CALC || state == LOAD);
  assign runNow     = iEn & (frameRun | frameStart);
  assign hFull      = colLast & hzLast;
  assign hStart     = runNow & iDE & ~deQ;
  // Pixels past the last column do not advance the position (saturation).
  assign hStep      = runNow & iDE & deQ & ~hFull;
  assign lineEv     = iEn & frameRun & deQ & ~iDE;
  // Row and in-zone line counters wrap to 0 on their own at the last line.
  assign frameEv    = rowCarry;
  assign posClr     = ~iEn | hStart | lineEv;
  bl_mod_counter #(.N(ZONE_W)) uHz (
    .iODCK(iODCK), .iSYS_rst(iSYS_rst), .iClr(posClr), .iInc(hStep),
    .oCount(hz), .oLast(hzLast), .oCarry(hzCarry)
  );
  bl_mod_counter #(.N(ZONE_COLS)) uCol (
    .iODCK(iODCK), .iSYS_rst(iSYS_rst), .iClr(posClr), .iInc(hzCarry),
    .oCount(col), .oLast(colLast), .oCarry(colCarry)
  );
  bl_mod_counter #(.N(ZONE_H)) uVz (
    .iODCK(iODCK), .iSYS_rst(iSYS_rst), .iClr(~iEn), .iInc(lineEv),
    .oCount(vz), .oLast(vzLast), .oCarry(vzCarry)
  );
  bl_mod_counter #(.N(ZONE_ROWS)) uRow (
    .iODCK(iODCK), .iSYS_rst(iSYS_rst), .iClr(~iEn), .iInc(vzCarry),
    .oCount(row), .oLast(rowLast), .oCarry(rowCarry)
  );
  // The edge that ends the load strobe restarts the duty phase; that beats the wrap.
  bl_mod_counter #(.N(DUTY_PERIOD)) uDuty (
    .iODCK(iODCK), .iSYS_rst(iSYS_rst), .iClr(~iEn | oPWM_load), .iInc(iEn),
    .oCount(duty), .oLast(dutyLast), .oCarry(dutyCarry)
  );
  assign unusedSigs = ^{colCarry, dutyLast, dutyCarry};
  assign oH_Count            = 12'(32'(col) * ZONE_W + 32'(hz));
  assign oV_Count            = 12'(32'(row) * ZONE_H + 32'(vz));
  assign oZone_Col           = 4'(col);
  assign oZone_Row           = 4'(row);
  assign oH_Block_Duty_Count = 7'(duty);
  assign oState              = state;
  always_ff @(posedge iODCK or negedge iSYS_rst)
    if (!iSYS_rst) begin
      state        <= IDLE;
      deQ          <= 1'b0;
      frameRun     <= 1'b0;
      satQ         <= 1'b0;
      oZone_Valid  <= 1'b0;
      oLine_End    <= 1'b0;
      oFrame_End   <= 1'b0;
      oErr_Overrun <= 1'b0;
    end else begin
      state        <= nextState;
      deQ          <= iDE;
      frameRun     <= iEn & ~frameEv & (frameRun | frameStart);
      satQ         <= runNow & iDE & deQ & hFull;
      oZone_Valid  <= runNow & iDE;
      oLine_End    <= lineEv;
      oFrame_End   <= frameEv;
      oErr_Overrun <= oErr_Overrun | (frameStart & (state == CALC));
    end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = WAIT_DE;
      WAIT_DE: if (frameStart) nextState = ACTIVE;
      ACTIVE:  if (oFrame_End) nextState = CALC;
      CALC:    if (iCalc_ack) nextState = LOAD;
      LOAD:    nextState = (frameRun | frameStart) ? ACTIVE : WAIT_DE;
      default: nextState = IDLE;
    endcase
    if (!iEn) nextState = IDLE;
    oCalc_req = state == CALC;
    oPWM_load = (state == LOAD) & iEn;
    // satQ suppresses repeats while a long line is held at the last pixel.
    oZone_End = oZone_Valid & hzLast & ~satQ;
  end
endmodule
